// File: rtl/jk_pkg.sv
// Shared encodings for the JK counter bank: operating modes and JK input pairs.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_JK   = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    // {j, k} pairs as seen by a single stage
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop stage with asynchronous active-high reset to 0.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_CLEAR:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_bank.sv
// Bank of JK stages acting as a loadable modulo up/down counter or raw JK register.
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic             wrap_d;
    logic             q_at_max;
    logic             q_zero;
    logic             q_over;

    assign q_at_max = (q >= MAX);
    assign q_zero   = (q == '0);
    assign q_over   = (32'(q) >= MODULUS);

    // Counting and loading pick a target value; the stages are then steered
    // there with set/clear pairs, so the JK cells are the only state.
    always_comb begin
        target = q;
        wrap_d = 1'b0;
        j_eff  = '0;
        k_eff  = '0;
        if (load) begin
            target = (32'(d) >= MODULUS) ? MAX : d;
        end else begin
            unique case (mode_e'(mode))
                MODE_HOLD: target = q;
                MODE_JK:   target = q;
                MODE_UP: begin
                    if (q_at_max) begin
                        target = '0;
                        wrap_d = 1'b1;
                    end else begin
                        target = q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q_zero) begin
                        target = MAX;
                        wrap_d = 1'b1;
                    end else if (q_over) begin
                        target = MAX;
                    end else begin
                        target = q - WIDTH'(1);
                    end
                end
            endcase
        end
        if (en) begin
            if (!load && (mode_e'(mode) == MODE_JK)) begin
                j_eff = j;
                k_eff = k;
            end else begin
                j_eff = target & ~q;
                k_eff = ~target & q;
            end
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        jk_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_eff[i]),
            .k   (k_eff[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else if (en) begin
            wrap <= wrap_d;
        end
    end

    assign qb = ~q;
    assign tc = en & ~load &
                (((mode == MODE_UP) & q_at_max) | ((mode == MODE_DOWN) & q_zero));

endmodule

// File: tb/tb_jk_counter_bank.sv
// Scoreboard bench for jk_counter_bank: directed scenarios plus random traffic.
module tb_jk_counter_bank;

    localparam int W = 4;
    localparam int M = 10;

    typedef struct {
        bit         imm;
        logic       tc;
        logic [3:0] q;
        logic       wrap;
    } rec_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] d    = '0;
    logic [3:0] j    = '0;
    logic [3:0] k    = '0;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
    logic       wrap;

    int   n_tests  = 0;
    int   n_fail   = 0;
    bit   drv_done = 1'b0;
    rec_t sb[$];
    int   mq = 0;
    bit   mw = 1'b0;

    always #5 clk = ~clk;

    jk_counter_bank #(
        .WIDTH   (W),
        .MODULUS (M)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .load (load),
        .d    (d),
        .j    (j),
        .k    (k),
        .q    (q),
        .qb   (qb),
        .tc   (tc),
        .wrap (wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_tc(input bit e, input bit l, input int md);
        return e && !l && ((md == 2 && mq >= M - 1) || (md == 3 && mq == 0));
    endfunction

    task automatic model_step(input bit e, input int md, input bit l,
                              input int dv, input int jv, input int kv);
        logic [3:0] v;
        if (!e) return;
        mw = 1'b0;
        if (l) begin
            mq = (dv >= M) ? M - 1 : dv;
        end else if (md == 1) begin
            v = mq[3:0];
            for (int i = 0; i < W; i++) begin
                if (jv[i] && kv[i])       v[i] = ~v[i];
                else if (jv[i])           v[i] = 1'b1;
                else if (kv[i])           v[i] = 1'b0;
            end
            mq = int'(v);
        end else if (md == 2) begin
            if (mq >= M - 1) begin
                mq = 0;
                mw = 1'b1;
            end else begin
                mq = mq + 1;
            end
        end else if (md == 3) begin
            if (mq == 0) begin
                mq = M - 1;
                mw = 1'b1;
            end else if (mq >= M) begin
                mq = M - 1;
            end else begin
                mq = mq - 1;
            end
        end
    endtask

    task automatic cyc(input bit e, input int md, input bit l,
                       input int dv, input int jv, input int kv);
        rec_t r;
        @(posedge clk);
        #2;
        rst  = 1'b0;
        en   = e;
        mode = 2'(md);
        load = l;
        d    = 4'(dv);
        j    = 4'(jv);
        k    = 4'(kv);
        r.imm  = 1'b0;
        r.tc   = model_tc(e, l, md);
        model_step(e, md, l, dv, jv, kv);
        r.q    = 4'(mq);
        r.wrap = mw;
        sb.push_back(r);
    endtask

    // Assert reset between edges; expectations are checked without waiting for an edge.
    task automatic rst_pulse();
        rec_t r;
        @(posedge clk);
        #2;
        rst = 1'b1;
        mq  = 0;
        mw  = 1'b0;
        r.imm  = 1'b1;
        r.tc   = model_tc(en, load, int'(mode));
        r.q    = 4'd0;
        r.wrap = 1'b0;
        sb.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            begin : driver
                rst_pulse();
                for (int i = 0; i < 12; i++) cyc(1, 2, 0, 0, 0, 0);
                cyc(1, 0, 1, 0, 0, 0);
                cyc(1, 3, 0, 0, 0, 0);
                cyc(1, 0, 1, 15, 0, 0);
                cyc(1, 0, 0, 0, 0, 0);
                cyc(1, 0, 1, 0, 0, 0);
                cyc(1, 1, 0, 0, 4'b1010, 4'b0000);
                cyc(1, 1, 0, 0, 4'b1111, 4'b1111);
                cyc(1, 1, 0, 0, 4'b0000, 4'b0100);
                cyc(1, 1, 0, 0, 4'b1100, 4'b0011);
                cyc(1, 2, 0, 0, 0, 0);
                cyc(1, 1, 0, 0, 4'b1100, 4'b0011);
                cyc(1, 3, 0, 0, 0, 0);
                cyc(1, 0, 1, 0, 0, 0);
                for (int i = 0; i < 6; i++) cyc(1, 2, 0, 0, 0, 0);
                rst_pulse();
                cyc(1, 2, 0, 0, 0, 0);
                cyc(1, 0, 1, 9, 0, 0);
                cyc(0, 2, 1, 3, 0, 0);
                cyc(1, 2, 1, 3, 0, 0);
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 39) == 0) begin
                        rst_pulse();
                    end else begin
                        cyc($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
                            $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                    end
                end
                drv_done = 1'b1;
            end
            begin : monitor
                rec_t       r;
                logic [3:0] eqb;
                while (!(drv_done && sb.size() == 0)) begin
                    @(negedge clk);
                    if (sb.size() > 0) begin
                        r = sb.pop_front();
                        chk("tc", 32'(tc), 32'(r.tc));
                        if (!r.imm) begin
                            @(posedge clk);
                            #1;
                        end
                        eqb = ~r.q;
                        chk(r.imm ? "q_reset" : "q", 32'(q), 32'(r.q));
                        chk(r.imm ? "qb_reset" : "qb", 32'(qb), 32'(eqb));
                        chk(r.imm ? "wrap_reset" : "wrap", 32'(wrap), 32'(r.wrap));
                    end
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_counter_bank.md
JK_COUNTER_BANK -- requirements
Module: jk_counter_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of JK stages (range 2..16).
REQ-002 Parameter MODULUS, default 16, count modulus (range 2..2**WIDTH).
REQ-003 Port clk  input  1  rising-edge clock; the only clock.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port en  input  1  global enable; 0 holds every stage.
REQ-006 Port mode  input  2  operating mode: 00 HOLD, 01 JK, 10 UP, 11 DOWN.
REQ-007 Port load  input  1  synchronous parallel load request.
REQ-008 Port d  input  WIDTH  parallel load value.
REQ-009 Port j  input  WIDTH  per-stage J inputs, used in JK mode only.
REQ-010 Port k  input  WIDTH  per-stage K inputs, used in JK mode only.
REQ-011 Port q  output  WIDTH  registered stage outputs.
REQ-012 Port qb  output  WIDTH  bitwise complement of q.
REQ-013 Port tc  output  1  combinational terminal-count flag.
REQ-014 Port wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-015 All state updates occur on the rising edge of clk.
REQ-016 Priority per edge: rst > (en=0 hold) > load > mode.
REQ-017 With en=0, q and wrap hold their current values.
REQ-018 With en=1 and load=1, q becomes d, or MODULUS-1 when d >= MODULUS; wrap becomes 0.
REQ-019 HOLD mode: q unchanged; wrap becomes 0.
REQ-020 JK mode: each bit i follows JK rules independently: (0,0) hold, (0,1) clear, (1,0) set, (1,1) toggle; no modulus clamp; wrap becomes 0.
REQ-021 UP mode: q < MODULUS-1 -> q+1, wrap becomes 0; q >= MODULUS-1 -> q becomes 0, wrap becomes 1.
REQ-022 DOWN mode: q == 0 -> q becomes MODULUS-1, wrap becomes 1; 0 < q < MODULUS -> q-1, wrap becomes 0; q >= MODULUS (only reachable via JK mode) -> q becomes MODULUS-1, wrap becomes 0.
REQ-023 wrap is high for exactly the one cycle following a wrap edge; back-to-back wraps (MODULUS=2 or repeated wrapping) produce consecutive high cycles.
REQ-024 tc = en AND ((mode=UP AND q >= MODULUS-1) OR (mode=DOWN AND q == 0)); tc is forced to 0 while load=1.
REQ-025 UP/DOWN transitions are realised by deriving per-stage J/K values from the current q and then applying the JK update of REQ-020; no separate adder register exists.
REQ-026 qb equals ~q at all times, including during reset.
REQ-027 A mode change takes effect on the next edge, with no extra latency cycle.

Reset
REQ-028 While rst=1: q=0, qb=all ones, wrap=0, independent of clk.
REQ-029 Deassertion of rst mid-operation: the first rising edge with rst=0 performs a normal update from q=0.
REQ-030 During reset, tc evaluates REQ-024 with q=0, so it is 1 when en=1 and mode=DOWN.

Structure
REQ-031 Shared package jk_pkg holds the mode encodings MODE_HOLD, MODE_JK, MODE_UP and MODE_DOWN, plus the JK input-pair constants.
REQ-032 Sub-module jk_ff_cell is instantiated WIDTH times, one per stage, with ports clk, rst, j, k, q (async active-high reset to 0).
REQ-033 The top level contains only the next-state J/K derivation logic, the wrap register and the tc logic.

Verification
REQ-034 WIDTH=4, MODULUS=10, UP, en=1 from q=0 for 12 edges -> q counts 1..9, 0, 1, 2; wrap is high only in the cycle after 9->0; tc is high while q=9.
REQ-035 DOWN from q=0 -> q=9 and wrap pulses; load d=15 -> q=9 (clamped).
REQ-036 JK mode from q=0000 with j=1010, k=0000 -> q=1010; then j=1111, k=1111 -> q=0101; then j=0000, k=0100 -> q=0001.
REQ-037 JK forces q=1100 (12 >= MODULUS=10), then UP -> q=0 with wrap=1; separately, q=12 then DOWN -> q=9 with wrap=0.
REQ-038 Counting UP at q=6, assert rst between clock edges -> q=0 and wrap=0 immediately, with no edge required; release rst -> the next edge gives q=1.
REQ-039 en=0 with load=1 and mode=UP -> q and wrap unchanged and tc=0; en=1 with load=1 and mode=UP at q=9 -> q=d, tc=0, no wrap.
